// File: rtl/kbd_ctrl.sv
// PS/2 keyboard receiver: synchronize, deglitch, deframe 11-bit frames, queue good bytes in a FIFO.
// Latency: a byte is visible on rd_data FILTER_LEN+3 clk cycles after the raw ps2_clk falling edge of its stop bit.
// Backpressure: none toward the keyboard; a push into a full FIFO is dropped and flagged in the sticky ovf bit.
module kbd_ctrl #(
  parameter int FIFO_AW    = 4,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        kbd_irq
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Two-flop synchronizers; idle line level is high, so they reset to 1.
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  // Bring the raw PS/2 lines into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  logic [FW-1:0] filt_cnt_q;
  logic          clk_f_q;
  logic          fall_q;

  // Deglitch: the filtered clock follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt_q <= '0;
      clk_f_q    <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s2_q != clk_f_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          clk_f_q    <= clk_s2_q;
          filt_cnt_q <= '0;
          fall_q     <= clk_f_q;  // only a 1->0 change produces a fall pulse
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            push;

  // Frame deserializer with inactivity timeout; push fires in the cycle the stop bit is sampled.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    idle_d    = idle_q;
    push      = 1'b0;

    if (state_q == IDLE || fall_q) begin
      idle_d = '0;
    end else if (idle_q == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      idle_d  = '0;
    end else begin
      idle_d = idle_q + TW'(1);
    end

    if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          push    = dat_s2_q && (^{shift_q, par_q});
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Deserializer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      idle_q    <= idle_d;
    end
  end

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             kbd_irq_q;
  logic             empty, full, pop, wr, drop;

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (FIFO_AW + 1)'(DEPTH));
    pop     = rd_en && !empty;
    wr      = push && (!full || pop);
    drop    = push && full && !pop;
    count_d = count_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop)       ovf_d = 1'b1;
    else if (rd_en) ovf_d = 1'b0;
  end

  // FIFO pointers, occupancy, sticky overflow and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      kbd_irq_q <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      kbd_irq_q <= (count_d != '0);
    end
  end

  // FIFO storage; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= shift_q;
  end

  // CPU read word; head is forced to zero when the FIFO is empty.
  always_comb begin
    rd_data = {22'b0, ovf_q, !empty, (empty ? 8'h00 : mem_q[rd_ptr_q])};
  end

  assign kbd_irq = kbd_irq_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Self-checking bench for kbd_ctrl: directed PS/2 frames plus randomized traffic against a queue model.
// The model sees a byte arrive on the exact clk edge the stop-bit fall is processed.
// Outputs are compared on every negedge once reset has been applied.
module tb_kbd_ctrl;

  localparam int FL = 8;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        kbd_irq;

  int n_chk  = 0;
  int n_pass = 0;

  logic       push_req;
  logic [7:0] push_byte;
  bit         rnd_rd;
  bit         chk_en;

  logic [7:0] mq [$];
  bit         movf;

  kbd_ctrl #(.FIFO_AW(4), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .kbd_irq (kbd_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_rd();
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    return {22'b0, movf, (mq.size() != 0), head};
  endfunction

  // Reference FIFO: a byte queue with a sticky overflow flag.
  always @(posedge clk) begin
    bit pop_m;
    if (rst) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      pop_m = rd_en && (mq.size() != 0);
      if (push_req && mq.size() == 16 && !pop_m) begin
        movf = 1'b1;
      end else begin
        if (pop_m) void'(mq.pop_front());
        if (push_req) mq.push_back(push_byte);
        if (rd_en) movf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd_data", rd_data, exp_rd());
      chk("model_kbd_irq", {31'b0, kbd_irq}, {31'b0, (mq.size() != 0)});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    rd_en    = rnd_rd && ($urandom_range(0, 29) == 0);
    push_req = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) cyc();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input bit glitch, input bit rd_at_stop);
    logic [10:0] bits;
    logic p, s;
    p = ~(^b) ^ bad_par;
    s = ~bad_stop;
    bits = {s, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 5) begin
        wait_cyc(14);
        ps2_clk = 1'b0;
        wait_cyc(FL - 2);
        ps2_clk = 1'b1;
        wait_cyc(half - 14 - (FL - 2));
      end else begin
        wait_cyc(half);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        wait_cyc(FL + 2);
        push_req  = s && (^{b, p});
        push_byte = b;
        if (rd_at_stop) rd_en = 1'b1;
        cyc();
        wait_cyc(half - FL - 3);
      end else begin
        wait_cyc(half);
      end
      ps2_clk = 1'b1;
    end
    wait_cyc(half);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(24);
      ps2_clk = 1'b0;
      wait_cyc(24);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic read_chk(input string nm, input logic [31:0] exp);
    chk(nm, rd_data, exp);
    rd_en = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    push_req = 1'b0; push_byte = 8'h00; rnd_rd = 1'b0; chk_en = 1'b0;
    cyc();
    chk_en = 1'b1;
    wait_cyc(2);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_kbd_irq", {31'b0, kbd_irq}, 32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // Single good scancode, then one pop.
    send_frame(8'h1C, 0, 0, 24, 0, 0);
    chk("t032_kbd_irq", {31'b0, kbd_irq}, 32'h1);
    read_chk("t032_data", 32'h0000011C);
    chk("t032_empty", rd_data, 32'h0);
    chk("t032_irq_low", {31'b0, kbd_irq}, 32'h0);

    // Bad parity frame dropped, good one kept.
    send_frame(8'hF0, 1, 0, 24, 0, 0);
    chk("t033_after_bad", rd_data, 32'h0);
    send_frame(8'h1C, 0, 0, 24, 0, 0);
    read_chk("t033_data", 32'h0000011C);
    chk("t033_count1", rd_data, 32'h0);

    // Bad stop bit dropped.
    send_frame(8'h42, 0, 1, 24, 0, 0);
    chk("bad_stop_drop", rd_data, 32'h0);

    // Overflow: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) send_frame(8'(i), 0, 0, 24, 0, 0);
    chk("t034_full_ovf", rd_data, 32'h00000300);
    read_chk("t034_rd0", 32'h00000300);
    for (int i = 1; i < 16; i++) read_chk("t034_rd", 32'h100 | 32'(i));
    chk("t034_drained", rd_data, 32'h0);

    // Short clock glitch mid-frame.
    send_frame(8'hA5, 0, 0, 24, 1, 0);
    read_chk("t035_glitch", 32'h000001A5);

    // Partial frame abandoned by timeout.
    send_partial(8'h0F, 5);
    wait_cyc(TO + 10);
    send_frame(8'h5A, 0, 0, 24, 0, 0);
    read_chk("t036_timeout", 32'h0000015A);
    chk("t036_only_one", rd_data, 32'h0);

    // Push and pop in the same cycle while empty.
    send_frame(8'h66, 0, 0, 24, 0, 1);
    read_chk("empty_push_pop", 32'h00000166);

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 0, 0, 24, 0, 0);
    send_frame(8'h30, 0, 0, 24, 0, 1);
    chk("t037_full_push_pop", rd_data, 32'h00000121);
    for (int i = 0; i < 16; i++) read_chk("t037_rd", 32'h100 | 32'(8'h21 + 8'(i)));
    chk("t037_drained", rd_data, 32'h0);

    // Reset in the middle of a frame flushes everything.
    send_frame(8'h77, 0, 0, 24, 0, 0);
    send_partial(8'h33, 4);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    cyc();
    chk("rst_midframe", rd_data, 32'h0);
    send_frame(8'h3C, 0, 0, 24, 0, 0);
    read_chk("after_rst", 32'h0000013C);

    // Randomized traffic with random pops.
    rnd_rd = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int  h;
      bit  g;
      h = $urandom_range(16, 28);
      g = (h >= 24) && ($urandom_range(0, 5) == 0);
      send_frame(8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 h, g, ($urandom_range(0, 3) == 0));
    end
    rnd_rd = 1'b0;
    cyc();
    for (int k = 0; k < 40 && mq.size() != 0; k++) begin
      rd_en = 1'b1;
      cyc();
    end
    wait_cyc(3);
    chk("final_empty", rd_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
